ram_dp_port_arb: RTL

- Two-requester arbiter that time-shares one port of the dual-port RAM model between two internal clients, for example a motion-estimation fetch engine and a reconstruction write-back engine.
- Converts client-side active-high request/write strobes into the RAM's active-low cen/wen/oen controls.
- Tracks the 1-cycle read latency so that each read returns to the client that issued it.
- Round-robin priority, with an optional per-client lock for bursts.

---
 rtl/ram_arb_pkg.sv | 11 +
 rtl/rr_arb2.sv | 59 +++++
 rtl/ram_dp_port_arb.sv | 81 ++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-client RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned NUM_CLIENTS  = 2;
  localparam int unsigned READ_LATENCY = 1;

  // RAM control pins are active low
  localparam logic RAM_EN  = 1'b0;
  localparam logic RAM_DIS = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a per-client ownership lock.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [NUM_CLIENTS-1:0] lock_i,
  output logic [NUM_CLIENTS-1:0] gnt_o,
  output logic                   owner_o
);

  logic prio_q, prio_d;
  logic owner_q, owner_d;
  logic locked_q, locked_d;
  logic win;

  always_comb begin
    gnt_o = '0;
    if (rst) begin
      gnt_o = '0;
    end else if (locked_q) begin
      // A locked owner holds the port even while idle
      gnt_o[owner_q] = req_i[owner_q];
    end else if (&req_i) begin
      gnt_o[prio_q] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end

  assign win = gnt_o[1];

  always_comb begin
    prio_d   = prio_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    if (|gnt_o) begin
      prio_d   = ~win;
      owner_d  = win;
      locked_d = lock_i[win];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/ram_dp_port_arb.sv
// Time-shares one RAM port between two clients and routes each read back to its issuer.
module ram_dp_port_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            req_i,
  input  logic [NUM_CLIENTS-1:0]            we_i,
  input  logic [NUM_CLIENTS-1:0]            lock_i,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_CLIENTS*WORD_WIDTH-1:0] wdata_i,
  output logic [NUM_CLIENTS-1:0]            gnt_o,
  output logic [NUM_CLIENTS-1:0]            rvalid_o,
  output logic [WORD_WIDTH-1:0]             rdata_o,
  output logic                              ram_cen_o,
  output logic                              ram_wen_o,
  output logic                              ram_oen_o,
  output logic [ADDR_WIDTH-1:0]             ram_addr_o,
  output logic [WORD_WIDTH-1:0]             ram_wdata_o,
  input  logic [WORD_WIDTH-1:0]             ram_rdata_i
);

  logic                   owner;
  logic                   sel;
  logic                   any_gnt;
  logic [NUM_CLIENTS-1:0] tag_d;
  logic [NUM_CLIENTS-1:0] tag_q [READ_LATENCY];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req_i),
    .lock_i  (lock_i),
    .gnt_o   (gnt_o),
    .owner_o (owner)
  );

  assign any_gnt = |gnt_o;
  assign sel     = gnt_o[1];

  always_comb begin
    ram_cen_o   = RAM_DIS;
    ram_wen_o   = RAM_DIS;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (any_gnt) begin
      ram_cen_o   = RAM_EN;
      ram_wen_o   = we_i[sel] ? RAM_EN : RAM_DIS;
      ram_addr_o  = sel ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
      ram_wdata_o = sel ? wdata_i[2*WORD_WIDTH-1:WORD_WIDTH] : wdata_i[WORD_WIDTH-1:0];
    end
  end

  // Read tag: which client's read is in flight
  always_comb begin
    tag_d = gnt_o & ~we_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Gated by rst so a read issued just before reset never returns
  assign rvalid_o  = rst ? '0 : tag_q[READ_LATENCY-1];
  assign ram_oen_o = (|rvalid_o) ? RAM_EN : RAM_DIS;
  assign rdata_o   = ram_rdata_i;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) gnt_o != 2'b11);
  a_gnt_req: assert property (@(posedge clk) disable iff (rst) (gnt_o & ~req_i) == '0);
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (rst) rvalid_o != 2'b11);
  a_owner: assert property (@(posedge clk) disable iff (rst) any_gnt |=> owner == $past(sel));

endmodule
